// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell walks the operands LSB first,
// one bit per clock, with a carry flip-flop chaining successive bits.
// Handshake: start in IDLE launches an add, busy covers the WIDTH
// processing cycles, done pulses once when sum/cout are valid.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter must be at least one bit wide so WIDTH=1 still builds.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;

    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_sum_bit;
    logic             w_carry_out;

    // The single shared full-adder cell, fed by the bit selected by the counter.
    always_comb begin
        w_a_bit     = r_a[r_cnt];
        w_b_bit     = r_b[r_cnt];
        w_sum_bit   = w_a_bit ^ w_b_bit ^ r_carry;
        w_carry_out = (w_a_bit & w_b_bit) | (w_a_bit & r_carry) | (w_b_bit & r_carry);
    end

    // Control FSM plus datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the operand registers are plain flops, not a memory, so they
            // are cleared here along with the rest of the state; an aborted
            // operation leaves nothing behind.
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below
            // reads the pre-edge values of r_cnt and r_carry.
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_result[r_cnt] <= w_sum_bit;
                    r_carry         <= w_carry_out;
                    r_cnt           <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_BIT) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here: no queuing.
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Result holds in r_result/r_carry until the next accepted start.
    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_result;
    assign cout = r_carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance for the
// handshake/timing scenarios and a 2-bit instance swept exhaustively.
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       cin2;
    logic       busy2;
    logic       done2;
    logic [1:0] sum2;
    logic       cout2;

    int errors = 0;
    int checks = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start2),
        .a     (a2),
        .b     (b2),
        .cin   (cin2),
        .busy  (busy2),
        .done  (done2),
        .sum   (sum2),
        .cout  (cout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full 8-bit operation: accept, eight SHIFT cycles, one DONE cycle, back to IDLE.
    task automatic run_op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic cv, input logic [7:0] es, input logic ec);
        a8     = av;
        b8     = bv;
        cin8   = cv;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check({tag, "_busy"}, 32'(busy8), 32'd1);
            check({tag, "_nodone"}, 32'(done8), 32'd0);
            tick();
        end
        check({tag, "_done"}, 32'(done8), 32'd1);
        check({tag, "_busy_off"}, 32'(busy8), 32'd0);
        check({tag, "_sum"}, 32'(sum8), 32'(es));
        check({tag, "_cout"}, 32'(cout8), 32'(ec));
        tick();
        check({tag, "_done_pulse"}, 32'(done8), 32'd0);
        check({tag, "_sum_hold"}, 32'(sum8), 32'(es));
        check({tag, "_cout_hold"}, 32'(cout8), 32'(ec));
    endtask

    initial begin
        int seen;
        int pulses;
        logic [2:0] exp3;

        rst_n  = 1'b0;
        start8 = 1'b0;
        a8     = 8'h00;
        b8     = 8'h00;
        cin8   = 1'b0;
        start2 = 1'b0;
        a2     = 2'b00;
        b2     = 2'b00;
        cin2   = 1'b0;

        // Reset state on both instances.
        tick();
        tick();
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_sum8",  32'(sum8),  32'd0);
        check("rst_cout8", 32'(cout8), 32'd0);
        check("rst_busy2", 32'(busy2), 32'd0);
        check("rst_done2", 32'(done2), 32'd0);
        check("rst_sum2",  32'(sum2),  32'd0);
        check("rst_cout2", 32'(cout2), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic vectors, including wrap-around with carry out.
        run_op8("zero",  8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        run_op8("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op8("a5_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
        run_op8("3c_42", 8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0);

        // Operands and start disturbed mid-flight must not affect the result.
        a8     = 8'h0F;
        b8     = 8'h01;
        cin8   = 1'b0;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        start8 = 1'b1;
        a8     = 8'hFF;
        b8     = 8'hFF;
        cin8   = 1'b1;
        for (int i = 1; i < 8; i++) begin
            check("inflight_nodone", 32'(done8), 32'd0);
            tick();
        end
        check("inflight_done", 32'(done8), 32'd1);
        check("inflight_sum",  32'(sum8),  32'h10);
        check("inflight_cout", 32'(cout8), 32'd0);
        tick();
        check("inflight_idle_busy", 32'(busy8), 32'd0);
        start8 = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (busy8 || done8) seen++;
        end
        check("inflight_no_second_op", 32'(seen), 32'd0);
        check("inflight_sum_hold", 32'(sum8), 32'h10);

        // Reset in the middle of SHIFT aborts without a done pulse.
        a8     = 8'h12;
        b8     = 8'h34;
        cin8   = 1'b0;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("abort_busy_before", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_sum",  32'(sum8),  32'd0);
        check("abort_cout", 32'(cout8), 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        run_op8("after_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

        // start held high: one operation every WIDTH+2 cycles, one-cycle done each.
        a8     = 8'h3C;
        b8     = 8'h42;
        cin8   = 1'b0;
        start8 = 1'b1;
        tick();
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (done8) begin
                check("held_pulse_pos", 32'(i), 32'(8 + 10 * pulses));
                check("held_sum", 32'(sum8), 32'h7E);
                pulses++;
            end
            if (i == 29) start8 = 1'b0;
            tick();
        end
        check("held_pulse_count", 32'(pulses), 32'd3);
        check("held_stop_busy", 32'(busy8), 32'd0);

        // WIDTH=2 instance over every a, b, cin combination.
        for (int av = 0; av < 4; av++) begin
            for (int bv = 0; bv < 4; bv++) begin
                for (int cv = 0; cv < 2; cv++) begin
                    a2     = 2'(av);
                    b2     = 2'(bv);
                    cin2   = 1'(cv);
                    start2 = 1'b1;
                    tick();
                    start2 = 1'b0;
                    tick();
                    check("w2_busy", 32'(busy2), 32'd1);
                    tick();
                    exp3 = 3'(av + bv + cv);
                    check("w2_done", 32'(done2), 32'd1);
                    check($sformatf("w2_sum_a%0d_b%0d_c%0d", av, bv, cv),
                          32'({cout2, sum2}), 32'(exp3));
                    tick();
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
